partition_op_scheduler: RTL and testbench

PARTITION_OP_SCHEDULER -- requirements
Module: partition_op_scheduler

---
 rtl/partition_op_scheduler.sv | 166 ++++++++++++++++
 tb/tb_partition_op_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/partition_op_scheduler.sv
// Two-requester command scheduler for the partition core: round-robin grant,
// single-shot issue, bounded wait for completion, and a held response slot.
module partition_op_scheduler #(
  parameter int REGION_WIDTH   = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [15:0]               req_op,
  input  logic [2*REGION_WIDTH-1:0] req_arg0,
  input  logic [15:0]               req_arg1,
  input  logic [15:0]               req_arg2,
  output logic [7:0]                core_op,
  output logic                      core_op_valid,
  output logic [REGION_WIDTH-1:0]   core_pnew_region,
  output logic [7:0]                core_psplit_module_id,
  output logic [REGION_WIDTH-1:0]   core_psplit_mask,
  output logic [7:0]                core_pmerge_m1,
  output logic [7:0]                core_pmerge_m2,
  input  logic                      core_op_done,
  input  logic [7:0]                core_result_module_id,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [7:0]                rsp_module_id,
  output logic [1:0]                rsp_status,
  output logic                      busy,
  output logic [15:0]               ops_done_count
);

  localparam int NREQ = 2;
  localparam logic [7:0] OP_PNEW   = 8'h00;
  localparam logic [7:0] OP_PSPLIT = 8'h01;
  localparam logic [7:0] OP_PMERGE = 8'h02;
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ILLEGAL = 2'd2;
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [7:0]              op;
    logic [REGION_WIDTH-1:0] arg0;
    logic [7:0]              arg1;
    logic [7:0]              arg2;
  } cmd_t;

  function automatic logic is_legal(input logic [7:0] op);
    return (op == OP_PNEW) || (op == OP_PSPLIT) || (op == OP_PMERGE);
  endfunction

  state_t              state, state_d;
  cmd_t [NREQ-1:0]     req_cmd;
  cmd_t                cmd_q;
  logic                rr;
  logic [7:0]          wait_cnt;
  logic                rsp_id_q;
  logic [7:0]          rsp_mod_q;
  logic [1:0]          rsp_status_q;
  logic                grant;
  logic                gnt_idx;

  // Every command field is sliced per requester, 8-bit fields at [8i+7:8i].
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req_cmd[i].op   = req_op[8*i +: 8];
    assign req_cmd[i].arg0 = req_arg0[REGION_WIDTH*i +: REGION_WIDTH];
    assign req_cmd[i].arg1 = req_arg1[8*i +: 8];
    assign req_cmd[i].arg2 = req_arg2[8*i +: 8];
  end

  assign gnt_idx = req_valid[rr] ? rr : ~rr;

  always_comb begin
    state_d   = state;
    req_ready = '0;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gate keeps req_ready low while reset is held
        if ((|req_valid) && rst_n) begin
          grant              = 1'b1;
          req_ready[gnt_idx] = 1'b1;
          state_d            = is_legal(req_cmd[gnt_idx].op) ? ISSUE : RESP;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_op_done || (wait_cnt == TO_LAST)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr             <= 1'b0;
      wait_cnt       <= '0;
      cmd_q          <= '0;
      rsp_id_q       <= 1'b0;
      rsp_mod_q      <= '0;
      rsp_status_q   <= '0;
      ops_done_count <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (grant) begin
            cmd_q    <= req_cmd[gnt_idx];
            rr       <= ~gnt_idx;
            rsp_id_q <= gnt_idx;
            if (!is_legal(req_cmd[gnt_idx].op)) begin
              rsp_status_q <= ST_ILLEGAL;
              rsp_mod_q    <= 8'hFF;
            end
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          // completion wins over a timeout landing in the same cycle
          if (core_op_done) begin
            rsp_status_q <= ST_OK;
            rsp_mod_q    <= core_result_module_id;
          end else if (wait_cnt == TO_LAST) begin
            rsp_status_q <= ST_TIMEOUT;
            rsp_mod_q    <= 8'hFF;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            cmd_q <= '0;
            if ((rsp_status_q == ST_OK) && (ops_done_count != 16'hFFFF))
              ops_done_count <= ops_done_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic core_active;
  assign core_active = (state == ISSUE) || (state == WAIT);

  assign core_op_valid         = (state == ISSUE);
  assign core_op               = core_active ? cmd_q.op : 8'h00;
  assign core_pnew_region      = (core_active && cmd_q.op == OP_PNEW)   ? cmd_q.arg0 : '0;
  assign core_psplit_mask      = (core_active && cmd_q.op == OP_PSPLIT) ? cmd_q.arg0 : '0;
  assign core_psplit_module_id = (core_active && cmd_q.op == OP_PSPLIT) ? cmd_q.arg1 : 8'h00;
  assign core_pmerge_m1        = (core_active && cmd_q.op == OP_PMERGE) ? cmd_q.arg1 : 8'h00;
  assign core_pmerge_m2        = (core_active && cmd_q.op == OP_PMERGE) ? cmd_q.arg2 : 8'h00;

  assign rsp_valid     = (state == RESP);
  assign rsp_id        = rsp_valid ? rsp_id_q     : 1'b0;
  assign rsp_module_id = rsp_valid ? rsp_mod_q    : 8'h00;
  assign rsp_status    = rsp_valid ? rsp_status_q : 2'd0;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_partition_op_scheduler.sv
// Directed bench for partition_op_scheduler; expectations are hand-derived
// cycle by cycle from the command timeline.
module tb_partition_op_scheduler;
  localparam int RW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [15:0]   req_op;
  logic [2*RW-1:0] req_arg0;
  logic [15:0]   req_arg1;
  logic [15:0]   req_arg2;
  logic [7:0]    core_op;
  logic          core_op_valid;
  logic [RW-1:0] core_pnew_region;
  logic [7:0]    core_psplit_module_id;
  logic [RW-1:0] core_psplit_mask;
  logic [7:0]    core_pmerge_m1;
  logic [7:0]    core_pmerge_m2;
  logic          core_op_done;
  logic [7:0]    core_result_module_id;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [7:0]    rsp_module_id;
  logic [1:0]    rsp_status;
  logic          busy;
  logic [15:0]   ops_done_count;

  partition_op_scheduler #(.REGION_WIDTH(RW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_arg0(req_arg0), .req_arg1(req_arg1), .req_arg2(req_arg2),
    .core_op(core_op), .core_op_valid(core_op_valid),
    .core_pnew_region(core_pnew_region), .core_psplit_module_id(core_psplit_module_id),
    .core_psplit_mask(core_psplit_mask), .core_pmerge_m1(core_pmerge_m1),
    .core_pmerge_m2(core_pmerge_m2), .core_op_done(core_op_done),
    .core_result_module_id(core_result_module_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_module_id(rsp_module_id), .rsp_status(rsp_status),
    .busy(busy), .ops_done_count(ops_done_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int p0, ng, nr;
  int gnt_log[8];
  int rsp_log[8];

  always @(negedge clk) if (core_op_valid === 1'b1) n_pulse++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b01; req_op = '0; req_arg0 = '0; req_arg1 = '0;
    req_arg2 = '0; core_op_done = 1'b0; core_result_module_id = '0; rsp_ready = 1'b0;
    #3;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_opvalid", core_op_valid, 0);
    chk("rst_rspvalid", rsp_valid, 0);
    chk("rst_count", ops_done_count, 0);
    req_valid = 2'b00;
    cyc(); rst_n = 1'b1;

    // PNEW from requester 0, completion 3 cycles after issue
    cyc(); p0 = n_pulse;
    req_valid = 2'b01; req_op = 16'h0000; req_arg0 = {64'h0, 64'h7};
    #1 chk("pnew_grant", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    chk("pnew_issue_valid", core_op_valid, 1);
    chk("pnew_issue_op", core_op, 8'h00);
    chk("pnew_region", core_pnew_region, 64'h7);
    chk("pnew_ready_off", req_ready, 2'b00);
    cyc();
    chk("pnew_region_hold", core_pnew_region, 64'h7);
    chk("pnew_valid_once", core_op_valid, 0);
    cyc();
    cyc(); core_op_done = 1'b1; core_result_module_id = 8'h00;
    cyc(); core_op_done = 1'b0;
    chk("pnew_rsp_valid", rsp_valid, 1);
    chk("pnew_rsp_id", rsp_id, 0);
    chk("pnew_rsp_status", rsp_status, 2'd0);
    chk("pnew_rsp_mod", rsp_module_id, 8'h00);
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0;
    chk("pnew_rsp_drop", rsp_valid, 0);
    chk("pnew_count", ops_done_count, 1);
    chk("pnew_pulses", n_pulse - p0, 1);
    chk("pnew_idle_region", core_pnew_region, 64'h0);
    chk("pnew_idle_busy", busy, 0);

    rst_n = 1'b0;
    #1 chk("rst2_count", ops_done_count, 0);
    cyc(); rst_n = 1'b1;

    // Both requesters pending continuously: grants must alternate
    cyc();
    req_valid = 2'b11; req_op = 16'h0000; req_arg0 = {64'h2, 64'h1};
    core_op_done = 1'b1; core_result_module_id = 8'h33; rsp_ready = 1'b1;
    ng = 0; nr = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rr_onehot", ($countones(req_ready) <= 1), 1);
      if (req_ready != 2'b00) begin
        if (ng < 8) gnt_log[ng] = int'(req_ready[1]);
        ng++;
      end
      if (rsp_valid) begin
        if (nr < 8) rsp_log[nr] = int'(rsp_id);
        nr++;
        chk("rr_rsp_mod", rsp_module_id, 8'h33);
      end
      cyc();
    end
    req_valid = 2'b00; core_op_done = 1'b0; rsp_ready = 1'b0;
    chk("rr_ngrants", ng, 4);
    chk("rr_nrsp", nr, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant_order", gnt_log[k], k % 2);
      chk("rr_rsp_order", rsp_log[k], k % 2);
    end
    chk("rr_count", ops_done_count, 4);

    // PSPLIT from requester 0, then PMERGE from requester 1
    cyc();
    req_valid = 2'b01; req_op = 16'h0201; req_arg0 = {64'hDEAD, 64'h1};
    req_arg1 = 16'h0000; req_arg2 = 16'h5555;
    #1 chk("psplit_grant", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    chk("psplit_op", core_op, 8'h01);
    chk("psplit_valid", core_op_valid, 1);
    chk("psplit_mask", core_psplit_mask, 64'h1);
    chk("psplit_modid", core_psplit_module_id, 8'h00);
    chk("psplit_m1_zero", core_pmerge_m1, 8'h00);
    chk("psplit_m2_zero", core_pmerge_m2, 8'h00);
    chk("psplit_region_zero", core_pnew_region, 64'h0);
    cyc();
    chk("psplit_mask_hold", core_psplit_mask, 64'h1);
    core_op_done = 1'b1; core_result_module_id = 8'h04;
    cyc(); core_op_done = 1'b0;
    chk("psplit_rsp_id", rsp_id, 0);
    chk("psplit_rsp_status", rsp_status, 2'd0);
    chk("psplit_rsp_mod", rsp_module_id, 8'h04);
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0;
    chk("psplit_idle_op", core_op, 8'h00);
    chk("psplit_idle_mask", core_psplit_mask, 64'h0);
    req_valid = 2'b11; req_op = 16'h0207; req_arg0 = {64'hF0, 64'hF0};
    req_arg1 = 16'h0101; req_arg2 = 16'h0202;
    #1 chk("pmerge_grant_rr", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    chk("pmerge_op", core_op, 8'h02);
    chk("pmerge_m1", core_pmerge_m1, 8'h01);
    chk("pmerge_m2", core_pmerge_m2, 8'h02);
    chk("pmerge_region_zero", core_pnew_region, 64'h0);
    chk("pmerge_mask_zero", core_psplit_mask, 64'h0);
    chk("pmerge_modid_zero", core_psplit_module_id, 8'h00);
    cyc();
    chk("pmerge_m1_hold", core_pmerge_m1, 8'h01);
    core_op_done = 1'b1; core_result_module_id = 8'h12;
    cyc(); core_op_done = 1'b0;
    chk("pmerge_rsp_id", rsp_id, 1);
    chk("pmerge_rsp_status", rsp_status, 2'd0);
    chk("pmerge_rsp_mod", rsp_module_id, 8'h12);
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0;
    chk("pmerge_count", ops_done_count, 6);
    chk("pmerge_idle_m1", core_pmerge_m1, 8'h00);

    // Illegal opcode
    p0 = n_pulse;
    req_valid = 2'b01; req_op = 16'h0005;
    #1 chk("ill_grant", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    chk("ill_rsp_valid", rsp_valid, 1);
    chk("ill_status", rsp_status, 2'd2);
    chk("ill_mod", rsp_module_id, 8'hFF);
    chk("ill_id", rsp_id, 0);
    chk("ill_no_issue", core_op_valid, 0);
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0;
    chk("ill_pulses", n_pulse - p0, 0);
    chk("ill_count", ops_done_count, 6);
    chk("ill_rsp_drop", rsp_valid, 0);

    // Timeout with TIMEOUT_CYCLES=4, response held under backpressure
    req_valid = 2'b10; req_op = 16'h0000; req_arg0 = {64'h5, 64'h0};
    #1 chk("to_grant", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    chk("to_issue", core_op_valid, 1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("to_waiting", rsp_valid, 0);
      cyc();
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_status", rsp_status, 2'd1);
    chk("to_mod", rsp_module_id, 8'hFF);
    chk("to_id", rsp_id, 1);
    req_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("to_hold_ready", req_ready, 2'b00);
      chk("to_hold_valid", rsp_valid, 1);
      chk("to_hold_status", rsp_status, 2'd1);
      chk("to_hold_mod", rsp_module_id, 8'hFF);
      chk("to_hold_id", rsp_id, 1);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("to_hs_no_grant", req_ready, 2'b00);
    cyc(); rsp_ready = 1'b0;
    chk("to_next_grant", req_ready, 2'b01);
    chk("to_count", ops_done_count, 6);
    chk("to_rsp_drop", rsp_valid, 0);
    req_valid = 2'b00;
    #1 chk("to_ready_drop", req_ready, 2'b00);

    // Reset in the middle of WAIT
    req_valid = 2'b01; req_op = 16'h0000; req_arg0 = {64'h0, 64'hABC};
    #1 chk("mrst_grant", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    cyc();
    chk("mrst_region", core_pnew_region, 64'hABC);
    chk("mrst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_async_busy", busy, 0);
    chk("mrst_async_op", core_op, 8'h00);
    chk("mrst_async_region", core_pnew_region, 64'h0);
    chk("mrst_async_rsp", rsp_valid, 0);
    chk("mrst_async_count", ops_done_count, 0);
    core_op_done = 1'b1;
    cyc(); rst_n = 1'b1; core_op_done = 1'b0;
    cyc();
    chk("mrst_no_rsp", rsp_valid, 0);
    chk("mrst_idle", busy, 0);
    req_valid = 2'b11; req_arg0 = {64'h22, 64'h11};
    #1 chk("mrst_grant0", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    chk("mrst_region_new", core_pnew_region, 64'h11);
    cyc(); core_op_done = 1'b1; core_result_module_id = 8'h09;
    cyc(); core_op_done = 1'b0;
    chk("mrst_rsp_id", rsp_id, 0);
    chk("mrst_rsp_status", rsp_status, 2'd0);
    chk("mrst_rsp_mod", rsp_module_id, 8'h09);
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0;
    chk("mrst_count", ops_done_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
